// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type and the FIPS-197 forward S-box table.
`timescale 1ns/1ps
package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    // Row-major: entry index is {row, column} = {byte[7:4], byte[3:0]}.
    localparam aes_byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbytes_sbox_lut.sv
// Combinational forward S-box lookup for one AES state byte.
`timescale 1ns/1ps
module sbox_lut
    import aes_pkg::*;
(
    input  aes_byte_t olddata,
    output aes_byte_t newdata
);

    // NOTE: a continuous assign from a fully populated table cannot infer a latch;
    // every one of the 256 codes has a defined result.
    assign newdata = SBOX[olddata];

endmodule

// File: rtl/aes_sbytes.sv
// AES SubBytes for one byte: combinational substitution plus a flop-aligned copy.
`timescale 1ns/1ps
module aes_sbytes
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] olddata,
    output logic [7:0] newdata,
    output logic [7:0] newdata_reg
);

    aes_byte_t sub_byte;

    sbox_lut u_sbox_lut (
        .olddata (olddata),
        .newdata (sub_byte)
    );

    assign newdata = sub_byte;

    // NOTE: non-blocking assignment so the flop captures the value settled before
    // the edge; the async clear sits in the sensitivity list, not behind the clock.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            newdata_reg <= 8'h00;
        end else begin
            newdata_reg <= sub_byte;
        end
    end

endmodule

// File: tb/tb_aes_sbytes.sv
// Self-checking bench for aes_sbytes against an arithmetic GF(2^8) S-box model.
`timescale 1ns/1ps
module tb_aes_sbytes;

    logic       clk;
    logic       n_rst;
    logic [7:0] olddata;
    logic [7:0] newdata;
    logic [7:0] newdata_reg;
    logic       clk_run;

    int tests;
    int fails;

    typedef struct {
        logic [7:0] din;
        logic [7:0] expect_val;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] sb_q [$];

    aes_sbytes dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .olddata     (olddata),
        .newdata     (newdata),
        .newdata_reg (newdata_reg)
    );

    // Clock toggles only while clk_run is set, so the first phase runs clock-free.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse (x^254) followed by the FIPS-197 affine transform.
    function automatic logic [7:0] model_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        clk_run = 1'b0;
        n_rst   = 1'b0;
        olddata = 8'h53;

        vecs[0] = '{8'h43, 8'h1a};
        vecs[1] = '{8'h00, 8'h63};
        vecs[2] = '{8'hff, 8'h16};
        vecs[3] = '{8'h74, 8'h92};
        vecs[4] = '{8'h61, 8'hef};
        vecs[5] = '{8'h01, 8'h7c};
        vecs[6] = '{8'h53, 8'hed};

        // Reset held, no clock: register cleared, lookup still live.
        #6;
        check("reset_reg", newdata_reg, 8'h00);
        check("reset_comb", newdata, 8'hed);

        for (int i = 0; i < 7; i++) begin
            olddata = vecs[i].din;
            #6;
            check($sformatf("spot_%02h", vecs[i].din), newdata, vecs[i].expect_val);
        end

        for (int i = 0; i < 256; i++) begin
            olddata = 8'(i);
            #6;
            check($sformatf("sweep_%02h", i), newdata, model_sbox(8'(i)));
        end
        check("sweep_reg_in_reset", newdata_reg, 8'h00);

        // Release reset between edges; first edge afterwards loads S(0x53).
        olddata = 8'h53;
        clk_run = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("release_no_edge", newdata_reg, 8'h00);
        @(posedge clk); #1;
        check("release_load", newdata_reg, 8'hed);

        // Register latency: mid-cycle input change shows on newdata only.
        @(negedge clk);
        olddata = 8'h01;
        @(posedge clk); #1;
        check("lat_reg_01", newdata_reg, 8'h7c);
        olddata = 8'h43;
        #3;
        check("lat_comb_43", newdata, 8'h1a);
        check("lat_reg_hold", newdata_reg, 8'h7c);
        @(posedge clk); #1;
        check("lat_reg_43", newdata_reg, 8'h1a);

        // Async reset pulse between edges while holding 0x92.
        @(negedge clk);
        olddata = 8'h74;
        @(posedge clk); #1;
        check("async_pre", newdata_reg, 8'h92);
        #1;
        n_rst = 1'b0;
        #1;
        check("async_clear", newdata_reg, 8'h00);
        check("async_comb", newdata, 8'h92);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("async_wait_edge", newdata_reg, 8'h00);
        @(posedge clk); #1;
        check("async_reload", newdata_reg, 8'h92);

        // Random stream through the scoreboard: push on drive, pop after the edge.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            olddata = 8'($urandom_range(0, 255));
            sb_q.push_back(model_sbox(olddata));
            #1;
            check($sformatf("stream_comb_%0d", i), newdata, model_sbox(olddata));
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stream_empty_%0d: got empty scoreboard, expected one entry", i);
            end else begin
                check($sformatf("stream_reg_%0d", i), newdata_reg, sb_q.pop_front());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
